unsigned_div_16by8_seq: RTL and testbench

Sequential unsigned 16/8 divider: the inverse of the unsigned 8x8 multipliers in this library. It takes a 16-bit product-width dividend and an 8-bit divisor and returns an 8-bit quotient and an 8-bit remainder using radix-2 restoring division, one quotient bit per cycle. Operands enter on a valid/ready handshake and results leave on one. The block serves as the reconstruction/checking path beside the approximate multipliers. It also has an optional approximate mode that truncates the low L quotient iterations, mirroring the multipliers' l parameter.

---
 rtl/unsigned_div_16by8_seq_pkg.sv | 26 ++
 rtl/unsigned_div_16by8_seq_if.sv | 27 ++
 rtl/unsigned_div_16by8_seq_step.sv | 23 ++
 rtl/unsigned_div_16by8_seq.sv | 127 ++++++++++++
 tb/tb_unsigned_div_16by8_seq.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/unsigned_div_16by8_seq_pkg.sv
// Shared types and constants for the 16/8 restoring divider.
// DIV_APPROX_EN selects approximate mode (low L quotient iterations skipped).
package div_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int Q_W        = 8;

`ifdef DIV_APPROX_EN
  localparam bit APPROX_EN = 1'b1;
`else
  localparam bit APPROX_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Number of restoring iterations actually performed.
  function automatic logic [3:0] iter_count(input int l);
    return APPROX_EN ? 4'(Q_W - l) : 4'(Q_W);
  endfunction

endpackage

// File: rtl/unsigned_div_16by8_seq_if.sv
// Operand/result handshake bundle for unsigned_div_16by8_seq.
// Both sides are valid/ready: a transfer happens on a rising edge where valid && ready.
interface unsigned_div_16by8_seq_if;
  import div_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] z;
  logic [DIVISOR_W-1:0]  y;
  logic                  out_valid;
  logic                  out_ready;
  logic [Q_W-1:0]        q;
  logic [DIVISOR_W-1:0]  r;
  logic                  div_by_zero;
  logic                  overflow;

  modport master (
    output in_valid, z, y, out_ready,
    input  in_ready, out_valid, q, r, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, z, y, out_ready,
    output in_ready, out_valid, q, r, div_by_zero, overflow
  );

endinterface

// File: rtl/unsigned_div_16by8_seq_step.sv
// One combinational radix-2 restoring division step.
module div_restoring_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W:0]   p,
  input  logic                 din,
  input  logic [DIVISOR_W-1:0] d,
  output logic [DIVISOR_W:0]   p_next,
  output logic                 q_bit
);

  logic [DIVISOR_W+1:0] t;
  logic [DIVISOR_W:0]   diff;

  always_comb begin
    t      = {p, din};
    q_bit  = (t >= {2'b00, d});
    // When q_bit is set the true difference is below 2^9, so modulo-512 is exact.
    diff   = 9'(t[DIVISOR_W:0] - {1'b0, d});
    p_next = q_bit ? diff : t[DIVISOR_W:0];
  end

endmodule

// File: rtl/unsigned_div_16by8_seq.sv
// Sequential unsigned 16/8 restoring divider, one quotient bit per cycle.
// Build with DIV_APPROX_EN to run only 8-L iterations and bias the low L quotient bits.
module unsigned_div_16by8_seq
  import div_pkg::*;
#(
  parameter int L = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  unsigned_div_16by8_seq_if.slave   bus,
  output div_state_e                dbg_state
);

  localparam logic [3:0] N_ITER = iter_count(L);

  div_state_e           state_q, state_d;
  logic [3:0]           cnt_q;
  logic [7:0]           z_lo_q;
  logic [DIVISOR_W-1:0] y_q;
  logic [DIVISOR_W:0]   p_q;
  logic [Q_W-2:0]       q_acc_q;
  logic                 special_q, dbz_pend_q;
  logic [Q_W-1:0]       q_q;
  logic [DIVISOR_W-1:0] r_q;
  logic                 dbz_q, ovf_q;

  logic                 accept;
  logic [DIVISOR_W:0]   p_next;
  logic                 q_bit;
  logic [Q_W-1:0]       q_next, q_final;

  div_restoring_step u_step (
    .p      (p_q),
    .din    (z_lo_q[7]),
    .d      (y_q),
    .p_next (p_next),
    .q_bit  (q_bit)
  );

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign q_next = {q_acc_q, q_bit};

  always_comb begin
`ifdef DIV_APPROX_EN
    q_final = (q_next << L) | (Q_W'(1) << (L - 1));
`else
    q_final = q_next;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)    state_d = CALC;
      CALC:    if (cnt_q == 4'd1)   state_d = DONE;
      DONE:    if (bus.out_ready)   state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready    = (state_q == IDLE);
    bus.out_valid   = (state_q == DONE);
    bus.q           = q_q;
    bus.r           = r_q;
    bus.div_by_zero = dbz_q;
    bus.overflow    = ovf_q;
    dbg_state       = state_q;
  end

  // Datapath: special cases spend one CALC cycle so they report after E+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      z_lo_q     <= '0;
      y_q        <= '0;
      p_q        <= '0;
      q_acc_q    <= '0;
      special_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (accept) begin
      z_lo_q     <= bus.z[7:0];
      y_q        <= bus.y;
      p_q        <= {1'b0, bus.z[15:8]};
      q_acc_q    <= '0;
      dbz_pend_q <= (bus.y == '0);
      if ((bus.y == '0) || (bus.z[15:8] >= bus.y)) begin
        special_q <= 1'b1;
        cnt_q     <= 4'd1;
      end else begin
        special_q <= 1'b0;
        cnt_q     <= N_ITER;
      end
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q - 4'd1;
      if (special_q) begin
        q_q   <= '1;
        r_q   <= z_lo_q;
        dbz_q <= dbz_pend_q;
        ovf_q <= !dbz_pend_q;
      end else begin
        p_q     <= p_next;
        q_acc_q <= q_next[Q_W-2:0];
        z_lo_q  <= {z_lo_q[6:0], 1'b0};
        if (cnt_q == 4'd1) begin
          q_q   <= q_final;
          r_q   <= p_next[DIVISOR_W-1:0];
          dbz_q <= 1'b0;
          ovf_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_unsigned_div_16by8_seq.sv
// Scoreboard bench for unsigned_div_16by8_seq: directed vectors, backpressure and mid-operation reset.
module tb_unsigned_div_16by8_seq;
  import div_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  unsigned_div_16by8_seq_if bus();
  div_state_e dbg_state;

  unsigned_div_16by8_seq #(.L(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

`ifdef DIV_APPROX_EN
  localparam int N = 2;
`else
  localparam int N = 8;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // {q, r, div_by_zero, overflow}
  logic [17:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];

  function automatic logic [17:0] mk(input logic [7:0] q, input logic [7:0] r,
                                     input logic d, input logic o);
    return {q, r, d, o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [15:0] z, input logic [7:0] y,
                      input logic [17:0] exp, input int lat);
    bit got = 0;
    bus.z        = z;
    bus.y        = y;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no in_ready expected in_ready=1 z=%0h y=%0h", z, y);
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    acc_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.z        = 16'($urandom);
    bus.y        = 8'($urandom);
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got %0d pending results expected 0", name, exp_q.size());
      exp_q.delete();
      lat_q.delete();
      acc_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid && !prev_valid) begin
        if (lat_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_valid: got out_valid=1 expected no result pending");
        end else begin
          int l, a;
          l = lat_q.pop_front();
          a = acc_q.pop_front();
          chk("latency", 32'(cyc - a), 32'(l));
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got q=%0h r=%0h expected none", bus.q, bus.r);
        end else begin
          chk("result{q,r,dbz,ovf}",
              32'({bus.q, bus.r, bus.div_by_zero, bus.overflow}), 32'(exp_q.pop_front()));
        end
      end
      prev_valid = bus.out_valid;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},    32'(bus.in_ready),    32'd1);
    chk({tag, "_out_valid"},   32'(bus.out_valid),   32'd0);
    chk({tag, "_q"},           32'(bus.q),           32'd0);
    chk({tag, "_r"},           32'(bus.r),           32'd0);
    chk({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 32'd0);
    chk({tag, "_overflow"},    32'(bus.overflow),    32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] vz  [6];
  logic [7:0]  vy  [6];
  logic [17:0] vex [6];
  int          vlat[6];

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.z         = '0;
    bus.y         = '0;

    #2;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table: main function, special cases and the non-overflow boundary.
    vz[0] = 16'd1000;  vy[0] = 8'd7;
    vz[1] = 16'h1234;  vy[1] = 8'd0;   vex[1] = mk(8'hFF, 8'h34, 1'b1, 1'b0); vlat[1] = 1;
    vz[2] = 16'd2048;  vy[2] = 8'd8;   vex[2] = mk(8'hFF, 8'h00, 1'b0, 1'b1); vlat[2] = 1;
    vz[3] = 16'h07FF;  vy[3] = 8'd8;
    vz[4] = 16'hFEFF;  vy[4] = 8'hFF;
    vz[5] = 16'hFFFF;  vy[5] = 8'hFF;  vex[5] = mk(8'hFF, 8'hFF, 1'b0, 1'b1); vlat[5] = 1;
`ifdef DIV_APPROX_EN
    vex[0] = mk(8'd160, 8'd1,   1'b0, 1'b0);
    vex[3] = mk(8'd224, 8'd7,   1'b0, 1'b0);
    vex[4] = mk(8'd224, 8'd254, 1'b0, 1'b0);
`else
    vex[0] = mk(8'd142, 8'd6,   1'b0, 1'b0);
    vex[3] = mk(8'd255, 8'd7,   1'b0, 1'b0);
    vex[4] = mk(8'd255, 8'd254, 1'b0, 1'b0);
`endif
    vlat[0] = N; vlat[3] = N; vlat[4] = N;

    for (int i = 0; i < 6; i++) send(vz[i], vy[i], vex[i], vlat[i]);
    drain("drain_table");

    // Backpressure: hold DONE, poke in_valid, result must not move.
    bus.out_ready = 1'b0;
`ifdef DIV_APPROX_EN
    send(16'd100, 8'd10, mk(8'd32, 8'd1, 1'b0, 1'b0), N);
`else
    send(16'd100, 8'd10, mk(8'd10, 8'd0, 1'b0, 1'b0), N);
`endif
    begin
      bit seen = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus.out_valid) begin
          seen = 1;
          break;
        end
      end
      if (!seen) begin
        n_tests++;
        n_fail++;
        $display("FAIL bp_wait_valid: got out_valid=0 expected 1");
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.z        = 16'h0005;
      bus.y        = 8'd1;
      @(negedge clk);
`ifdef DIV_APPROX_EN
      chk("bp_q", 32'(bus.q), 32'd32);
      chk("bp_r", 32'(bus.r), 32'd1);
`else
      chk("bp_q", 32'(bus.q), 32'd10);
      chk("bp_r", 32'(bus.r), 32'd0);
`endif
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain("drain_bp");

    // Reset while CALC is in progress discards the operation.
    send(16'd1000, 8'd7, mk(8'd142, 8'd6, 1'b0, 1'b0), N);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Recovery after reset.
`ifdef DIV_APPROX_EN
    send(16'd255, 8'd1, mk(8'd224, 8'd0, 1'b0, 1'b0), N);
    send(16'd0,   8'd5, mk(8'd32,  8'd0, 1'b0, 1'b0), N);
`else
    send(16'd255, 8'd1, mk(8'd255, 8'd0, 1'b0, 1'b0), N);
    send(16'd0,   8'd5, mk(8'd0,   8'd0, 1'b0, 1'b0), N);
`endif
    send(16'h0100, 8'd1, mk(8'hFF, 8'h00, 1'b0, 1'b1), 1);
    drain("drain_after_reset");
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
